clk_switch_ctrl: RTL and testbench

- Control-plane successor to the two-input clock stabilizer.
- Runs on the always-running stable clock and arbitrates among NUM_SRC clock sources.
- Filters each source's asynchronous lock flag, sequences glitch-safe switchovers (gate, select, settle, ungate) and drives the binary select of an external glitch-free clock-mux tree.
- Falls back automatically to the default source when the active source loses lock.

---
 rtl/clk_switch_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_clk_switch_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_switch_ctrl.sv
// Glitch-safe clock-source switch controller on the stable clock: lock filtering, gate/select/settle/ungate sequencing, auto fallback.
// Optional statistics counters are enabled by defining CLK_SWITCH_CTRL_STATS_EN.
module clk_switch_ctrl #(
  parameter int NUM_SRC       = 4,
  parameter int SEL_W         = 2,
  parameter int DEFAULT_SRC   = 0,
  parameter int LOCK_FILT     = 8,
  parameter int GATE_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic               stable_clk,
  input  logic               resetn,
  input  logic [SEL_W-1:0]   req_sel,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [NUM_SRC-1:0] src_locked,
  output logic [SEL_W-1:0]   mux_sel,
  output logic               clk_en,
  output logic [SEL_W-1:0]   active_sel,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               fallback
`ifdef CLK_SWITCH_CTRL_STATS_EN
  ,
  output logic [15:0]        switch_count,
  output logic [7:0]         fallback_count
`endif
);

  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0,
    ST_IDLE    = 3'd1,
    ST_GATE    = 3'd2,
    ST_SWITCH  = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_RESUME  = 3'd5
  } state_t;

  localparam logic [SEL_W-1:0] DEF_SEL     = SEL_W'(DEFAULT_SRC);
  localparam logic [7:0]       FILT_LAST   = 8'(LOCK_FILT - 1);
  localparam logic [15:0]      GATE_LAST   = 16'(GATE_CYCLES - 1);
  localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  // Out-of-range indices simply match no source and read as unlocked.
  function automatic logic sel_locked(input logic [SEL_W-1:0] sel, input logic [NUM_SRC-1:0] lk);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int'(sel) == i) r = lk[i];
    end
    return r;
  endfunction

  logic [NUM_SRC-1:0] sync1_r, sync2_r, lock_f_r;
  logic [7:0]         run_cnt_r [NUM_SRC];
  state_t             state_r;
  logic [SEL_W-1:0]   target_r, mux_sel_r, active_sel_r;
  logic [15:0]        cnt_r;
  logic               clk_en_r, busy_r, done_r, err_r, fallback_r;
  logic               fb_trig_s, def_lost_s, abort_s;

  // Per-source synchronizer followed by a consecutive-sample run filter.
  always_ff @(posedge stable_clk or negedge resetn) begin
    if (!resetn) begin
      sync1_r  <= '0;
      sync2_r  <= '0;
      lock_f_r <= '0;
      for (int i = 0; i < NUM_SRC; i++) run_cnt_r[i] <= 8'd0;
    end else begin
      sync1_r <= src_locked;
      sync2_r <= sync1_r;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (sync2_r[i] == lock_f_r[i]) begin
          run_cnt_r[i] <= 8'd0;
        end else if (run_cnt_r[i] == FILT_LAST) begin
          lock_f_r[i]  <= sync2_r[i];
          run_cnt_r[i] <= 8'd0;
        end else begin
          run_cnt_r[i] <= run_cnt_r[i] + 8'd1;
        end
      end
    end
  end

  // Loss-of-lock conditions that override normal sequencing.
  always_comb begin
    fb_trig_s  = 1'b0;
    def_lost_s = 1'b0;
    abort_s    = 1'b0;
    if (state_r == ST_IDLE) begin
      fb_trig_s  = (active_sel_r != DEF_SEL) && !sel_locked(active_sel_r, lock_f_r);
      def_lost_s = (active_sel_r == DEF_SEL) && !lock_f_r[DEFAULT_SRC];
    end else if ((state_r == ST_GATE) || (state_r == ST_SWITCH) || (state_r == ST_SETTLE)) begin
      abort_s = !sel_locked(target_r, lock_f_r);
    end else begin
      abort_s = 1'b0;
    end
  end

  // Switch sequencer with registered outputs.
  always_ff @(posedge stable_clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_STARTUP;
      target_r     <= DEF_SEL;
      mux_sel_r    <= DEF_SEL;
      active_sel_r <= DEF_SEL;
      cnt_r        <= 16'd0;
      clk_en_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      fallback_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (abort_s) begin
        clk_en_r <= 1'b0;
        busy_r   <= 1'b1;
        cnt_r    <= 16'd0;
        if (target_r == DEF_SEL) begin
          state_r <= ST_STARTUP;
        end else begin
          target_r   <= DEF_SEL;
          fallback_r <= 1'b1;
          state_r    <= ST_GATE;
        end
      end else begin
        case (state_r)
          ST_STARTUP: begin
            clk_en_r  <= 1'b0;
            busy_r    <= 1'b1;
            mux_sel_r <= DEF_SEL;
            target_r  <= DEF_SEL;
            cnt_r     <= 16'd0;
            if (lock_f_r[DEFAULT_SRC]) state_r <= ST_SETTLE;
          end
          ST_IDLE: begin
            if (fb_trig_s) begin
              target_r   <= DEF_SEL;
              fallback_r <= 1'b1;
              clk_en_r   <= 1'b0;
              busy_r     <= 1'b1;
              cnt_r      <= 16'd0;
              state_r    <= ST_GATE;
            end else if (def_lost_s) begin
              clk_en_r <= 1'b0;
              busy_r   <= 1'b1;
              state_r  <= ST_STARTUP;
            end else if (req_valid) begin
              if (!sel_locked(req_sel, lock_f_r)) begin
                err_r <= 1'b1;
              end else begin
                fallback_r <= 1'b0;
                if (req_sel == active_sel_r) begin
                  done_r <= 1'b1;
                end else begin
                  target_r <= req_sel;
                  clk_en_r <= 1'b0;
                  busy_r   <= 1'b1;
                  cnt_r    <= 16'd0;
                  state_r  <= ST_GATE;
                end
              end
            end else begin
              busy_r <= 1'b0;
            end
          end
          ST_GATE: begin
            if (cnt_r == GATE_LAST) begin
              mux_sel_r <= target_r;
              cnt_r     <= 16'd0;
              state_r   <= ST_SWITCH;
            end else begin
              cnt_r <= cnt_r + 16'd1;
            end
          end
          ST_SWITCH: begin
            cnt_r   <= 16'd0;
            state_r <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (cnt_r == SETTLE_LAST) begin
              clk_en_r     <= 1'b1;
              active_sel_r <= target_r;
              done_r       <= 1'b1;
              state_r      <= ST_RESUME;
            end else begin
              cnt_r <= cnt_r + 16'd1;
            end
          end
          ST_RESUME: begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
          default: begin
            clk_en_r <= 1'b0;
            busy_r   <= 1'b1;
            state_r  <= ST_STARTUP;
          end
        endcase
      end
    end
  end

  // Ready drops in the very cycle a lock loss is seen so fallback wins over a request.
  assign req_ready  = (state_r == ST_IDLE) && !fb_trig_s && !def_lost_s;
  assign mux_sel    = mux_sel_r;
  assign active_sel = active_sel_r;
  assign clk_en     = clk_en_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign fallback   = fallback_r;

`ifdef CLK_SWITCH_CTRL_STATS_EN
  logic [15:0] switch_count_r;
  logic [7:0]  fallback_count_r;
  logic        fb_evt_s;

  assign fb_evt_s = fb_trig_s || (abort_s && (target_r != DEF_SEL));

  // Saturating event counters.
  always_ff @(posedge stable_clk or negedge resetn) begin
    if (!resetn) begin
      switch_count_r   <= 16'd0;
      fallback_count_r <= 8'd0;
    end else begin
      if ((state_r == ST_RESUME) && (switch_count_r != 16'hFFFF)) begin
        switch_count_r <= switch_count_r + 16'd1;
      end else begin
        switch_count_r <= switch_count_r;
      end
      if (fb_evt_s && (fallback_count_r != 8'hFF)) begin
        fallback_count_r <= fallback_count_r + 8'd1;
      end else begin
        fallback_count_r <= fallback_count_r;
      end
    end
  end

  assign switch_count   = switch_count_r;
  assign fallback_count = fallback_count_r;
`endif

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Scoreboard bench for clk_switch_ctrl: expected done/err events are queued at request time and popped on each pulse.
module tb_clk_switch_ctrl;
  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 2;

  logic               stable_clk = 1'b0;
  logic               resetn     = 1'b0;
  logic [SEL_W-1:0]   req_sel    = 2'd0;
  logic               req_valid  = 1'b0;
  logic               req_ready;
  logic [NUM_SRC-1:0] src_locked = 4'b0001;
  logic [SEL_W-1:0]   mux_sel, active_sel;
  logic               clk_en, busy, done, err, fallback;
`ifdef CLK_SWITCH_CTRL_STATS_EN
  logic [15:0]        switch_count;
  logic [7:0]         fallback_count;
`endif

  typedef struct packed {
    logic [1:0]       kind;
    logic [SEL_W-1:0] sel;
  } sb_item_t;

  localparam logic [1:0] EV_DONE = 2'b10;
  localparam logic [1:0] EV_ERR  = 2'b01;

  sb_item_t sb_q[$];
  sb_item_t mon_e;
  int       checks   = 0;
  int       failures = 0;
  int       n;

  clk_switch_ctrl dut (
    .stable_clk (stable_clk),
    .resetn     (resetn),
    .req_sel    (req_sel),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .src_locked (src_locked),
    .mux_sel    (mux_sel),
    .clk_en     (clk_en),
    .active_sel (active_sel),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .fallback   (fallback)
`ifdef CLK_SWITCH_CTRL_STATS_EN
    ,
    .switch_count   (switch_count),
    .fallback_count (fallback_count)
`endif
  );

  always #5 stable_clk = ~stable_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge stable_clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!req_ready && k < 300) begin
      tick();
      k++;
    end
    check_eq(tag, req_ready, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
    end
    check_eq(tag, busy, 0);
  endtask

  task automatic send(input logic [SEL_W-1:0] sel);
    req_sel   = sel;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic push(input logic [1:0] kind, input logic [SEL_W-1:0] sel);
    sb_q.push_back('{kind: kind, sel: sel});
  endtask

  task automatic startup(input string tag);
    int k = 0;
    while (!clk_en && k < 300) begin
      tick();
      k++;
    end
    check_eq(tag, k, 75);
    check_eq("startup_mux", mux_sel, 0);
    check_eq("startup_active", active_sel, 0);
    wait_idle("startup_idle");
  endtask

  always @(negedge stable_clk) begin
    if (resetn && (done || err)) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected", {done, err}, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("sb_kind", {done, err}, mon_e.kind);
        check_eq("sb_active", active_sel, mon_e.sel);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    repeat (3) tick();
    check_eq("rst_mux", mux_sel, 0);
    check_eq("rst_active", active_sel, 0);
    check_eq("rst_clk_en", clk_en, 0);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done_err", {done, err}, 0);
    check_eq("rst_fallback", fallback, 0);

    push(EV_DONE, 2'd0);
    resetn = 1'b1;
    startup("startup_latency");

    // Switch 0 -> 2 and measure the gated window.
    src_locked = 4'b0101;
    repeat (12) tick();
    wait_ready("sw_ready");
    push(EV_DONE, 2'd2);
    send(2'd2);
    low = 0;
    while (!clk_en && low < 500) begin
      low++;
      if (low == 4) check_eq("sw_mux_before", mux_sel, 0);
      if (low == 5) check_eq("sw_mux_after", mux_sel, 2);
      tick();
    end
    check_eq("sw_low_cycles", low, 69);
    check_eq("sw_active", active_sel, 2);
    check_eq("sw_mux", mux_sel, 2);
    wait_idle("sw_idle");

    // Rejections: unlocked source and a short glitch.
    wait_ready("rej1_ready");
    push(EV_ERR, 2'd2);
    send(2'd1);
    check_eq("rej1_busy", busy, 0);
    check_eq("rej1_mux", mux_sel, 2);
    src_locked[3] = 1'b1;
    repeat (5) tick();
    src_locked[3] = 1'b0;
    wait_ready("rej3_ready");
    push(EV_ERR, 2'd2);
    send(2'd3);
    check_eq("rej3_busy", busy, 0);
    check_eq("rej3_mux", mux_sel, 2);

    // A 7-cycle lock drop is filtered out.
    src_locked[2] = 1'b0;
    repeat (7) tick();
    src_locked[2] = 1'b1;
    repeat (20) tick();
    check_eq("drop7_fallback", fallback, 0);
    check_eq("drop7_active", active_sel, 2);
    check_eq("drop7_busy", busy, 0);

    // Long drop: fallback triggers in the same cycle as a request.
    src_locked[2] = 1'b0;
    repeat (10) tick();
    check_eq("fb_ready_low", req_ready, 0);
    push(EV_DONE, 2'd0);
    send(2'd0);
    check_eq("fb_flag", fallback, 1);
    check_eq("fb_busy", busy, 1);
    check_eq("fb_clk_en", clk_en, 0);
    wait_idle("fb_idle");
    check_eq("fb_mux", mux_sel, 0);
    check_eq("fb_active", active_sel, 0);
    check_eq("fb_clk_en_back", clk_en, 1);
    check_eq("fb_sticky", fallback, 1);
    wait_ready("resub_ready");
    push(EV_DONE, 2'd0);
    send(2'd0);
    check_eq("resub_fb_clear", fallback, 0);
    check_eq("resub_busy", busy, 0);

    // Reset asserted mid-SETTLE.
    src_locked = 4'b0101;
    repeat (12) tick();
    wait_ready("mid_ready");
    send(2'd2);
    repeat (20) tick();
    check_eq("mid_busy", busy, 1);
    check_eq("mid_mux", mux_sel, 2);
    check_eq("mid_clk_en", clk_en, 0);
`ifdef CLK_SWITCH_CTRL_STATS_EN
    check_eq("stats_switch", switch_count, 3);
    check_eq("stats_fallback", fallback_count, 1);
`endif
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_mux", mux_sel, 0);
    check_eq("mid_rst_busy", busy, 0);
    tick();
    check_eq("mid_rst_active", active_sel, 0);
    check_eq("mid_rst_clk_en", clk_en, 0);
    check_eq("mid_rst_ready", req_ready, 0);
`ifdef CLK_SWITCH_CTRL_STATS_EN
    check_eq("stats_rst_switch", switch_count, 0);
`endif
    push(EV_DONE, 2'd0);
    resetn = 1'b1;
    startup("restart_latency");
`ifdef CLK_SWITCH_CTRL_STATS_EN
    check_eq("stats_restart_switch", switch_count, 1);
    check_eq("stats_restart_fallback", fallback_count, 0);
`endif
    repeat (3) tick();
    n = sb_q.size();
    check_eq("sb_drain", n, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
